// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a synchronous-read instruction
// memory, and presents each fetched instruction with its opcode/branch fields.
module fetch_unit #(
   parameter int PC_W     = 10,
   parameter int INSTR_W  = 9,
   parameter int RESET_PC = 0,
   parameter int CNT_W    = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               halt_req,
   input  logic               branch_taken,
   input  logic [PC_W-1:0]    branch_target,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] instr,
   output logic               instr_valid,
   output logic [2:0]         opcode,
   output logic [1:0]         branch_bits,
   output logic [PC_W-1:0]    pc,
   output logic               running,
   output logic               done,
   output logic [CNT_W-1:0]   cycle_count
);

   typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN, S_HALTED} state_t;

   localparam logic [PC_W-1:0]  RST_PC  = PC_W'(RESET_PC);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t            state_q, state_d;
   logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [PC_W-1:0]   tgt_q, tgt_d;
   logic              squash_q, squash_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [PC_W-1:0]   addr;
   logic              vld;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         fetch_pc_q <= RST_PC;
         pc_q       <= RST_PC;
         tgt_q      <= RST_PC;
         squash_q   <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         pc_q       <= pc_d;
         tgt_q      <= tgt_d;
         squash_q   <= squash_d;
         cnt_q      <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      pc_d       = pc_q;
      tgt_d      = tgt_q;
      squash_d   = 1'b0;
      cnt_d      = cnt_q;
      addr       = RST_PC;
      vld        = 1'b0;
      unique case (state_q)
         S_IDLE, S_HALTED: begin
            if (start) begin
               state_d    = S_PRIME;
               fetch_pc_d = RST_PC;
               cnt_d      = '0;
            end
         end
         S_PRIME: begin
            addr       = fetch_pc_q;
            fetch_pc_d = addr + 1'b1;
            pc_d       = addr;
            cnt_d      = sat_inc(cnt_q);
            state_d    = S_RUN;
         end
         S_RUN: begin
            vld   = !squash_q;
            cnt_d = sat_inc(cnt_q);
            // The squashed slot is the one cycle where the redirect address is issued.
            addr  = squash_q ? tgt_q : fetch_pc_q;
            if (vld && halt_req) begin
               state_d = S_HALTED;
            end else begin
               fetch_pc_d = addr + 1'b1;
               pc_d       = addr;
               if (vld && branch_taken) begin
                  squash_d = 1'b1;
                  tgt_d    = branch_target;
               end
            end
         end
      endcase
   end

   assign imem_addr   = addr;
   assign instr_valid = vld;
   assign instr       = vld ? imem_rdata : '0;
   assign opcode      = instr[8:6];
   assign branch_bits = instr[5:4];
   assign pc          = pc_q;
   assign running     = (state_q == S_PRIME) || (state_q == S_RUN);
   assign done        = (state_q == S_HALTED);
   assign cycle_count = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed/randomized bench for fetch_unit with a program-order reference model.
module tb_fetch_unit;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   // Main instance (default widths)
   logic       reset, start, halt_req, branch_taken;
   logic [9:0] branch_target, imem_addr, pc;
   logic [8:0] imem_rdata, instr;
   logic       instr_valid, running, done;
   logic [2:0] opcode;
   logic [1:0] branch_bits;
   logic [15:0] cycle_count;
   logic [8:0] mem [1024];

   fetch_unit dut (
      .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .imem_addr(imem_addr), .imem_rdata(imem_rdata), .instr(instr),
      .instr_valid(instr_valid), .opcode(opcode), .branch_bits(branch_bits),
      .pc(pc), .running(running), .done(done), .cycle_count(cycle_count)
   );

   always_ff @(posedge clk) imem_rdata <= mem[imem_addr];

   // Narrow instance for address wrap and counter saturation
   logic       s_start, s_halt, s_bt;
   logic [3:0] s_tg, s_addr, s_pc, s_cnt;
   logic [8:0] s_rdata, s_instr;
   logic       s_valid, s_running, s_done;
   logic [2:0] s_opcode;
   logic [1:0] s_bbits;
   logic [8:0] smem [16];

   fetch_unit #(.PC_W(4), .CNT_W(4)) dut_s (
      .clk(clk), .reset(reset), .start(s_start), .halt_req(s_halt),
      .branch_taken(s_bt), .branch_target(s_tg),
      .imem_addr(s_addr), .imem_rdata(s_rdata), .instr(s_instr),
      .instr_valid(s_valid), .opcode(s_opcode), .branch_bits(s_bbits),
      .pc(s_pc), .running(s_running), .done(s_done), .cycle_count(s_cnt)
   );

   always_ff @(posedge clk) s_rdata <= smem[s_addr];

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: 0 idle, 1 prime, 2 run, 3 halted
   int m_mode = 0;
   int m_pc   = 0;   // program address of the current slot
   int m_next = 0;   // next address in program order
   bit m_bub  = 0;   // current slot is the squashed successor of a taken branch
   int m_tgt  = 0;
   int m_cnt  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit m_valid();
      return (m_mode == 2) && !m_bub;
   endfunction

   task automatic check_main();
      logic [8:0] ei;
      bit ev;
      ev = m_valid();
      ei = ev ? mem[m_pc] : 9'd0;
      chk("instr_valid", {31'd0, instr_valid}, {31'd0, ev});
      chk("instr", {23'd0, instr}, {23'd0, ei});
      chk("opcode", {29'd0, opcode}, {29'd0, ei[8:6]});
      chk("branch_bits", {30'd0, branch_bits}, {30'd0, ei[5:4]});
      chk("running", {31'd0, running}, (m_mode == 1 || m_mode == 2) ? 32'd1 : 32'd0);
      chk("done", {31'd0, done}, (m_mode == 3) ? 32'd1 : 32'd0);
      chk("cycle_count", {16'd0, cycle_count}, m_cnt);
      if (m_mode == 0 || m_mode == 3 || ev)
         chk("pc", {22'd0, pc}, m_pc);
   endtask

   task automatic model_edge(input bit r, input bit st, input bit hr, input bit bt, input int tg);
      if (r) begin
         m_mode = 0; m_pc = 0; m_next = 0; m_bub = 0; m_cnt = 0;
      end else if (m_mode == 0 || m_mode == 3) begin
         if (st) begin m_mode = 1; m_cnt = 0; end
      end else begin
         m_cnt = (m_cnt == 65535) ? 65535 : m_cnt + 1;
         if (m_mode == 1) begin
            m_mode = 2; m_pc = 0; m_next = 1; m_bub = 0;
         end else if (m_valid() && hr) begin
            m_mode = 3;
         end else if (m_bub) begin
            m_pc = m_tgt; m_next = (m_tgt + 1) % 1024; m_bub = 0;
         end else begin
            m_pc = m_next; m_next = (m_next + 1) % 1024;
            if (bt) begin m_bub = 1; m_tgt = tg; end
         end
      end
   endtask

   task automatic tick(input bit r, input bit st, input bit hr, input bit bt, input int tg);
      reset = r; start = st; halt_req = hr; branch_taken = bt; branch_target = 10'(tg);
      check_main();
      @(posedge clk);
      model_edge(r, st, hr, bt, tg);
      #1;
   endtask

   task automatic to_valid();
      for (int i = 0; i < 4 && !m_valid(); i++) tick(0, 0, 0, 0, 0);
   endtask

   initial begin
      int cc;
      for (int i = 0; i < 1024; i++) mem[i] = 9'($urandom);
      for (int i = 0; i < 16; i++) smem[i] = 9'($urandom);
      reset = 1; start = 0; halt_req = 0; branch_taken = 0; branch_target = 0;
      s_start = 0; s_halt = 0; s_bt = 0; s_tg = 0;
      repeat (2) @(posedge clk);
      #1;

      // Narrow instance: wrap 14,15,0,1 and counter saturation at 15
      s_start = 1; tick(0, 0, 0, 0, 0);
      s_start = 0; tick(0, 0, 0, 0, 0);
      for (int k = 0; k < 20; k++) begin
         chk("s_valid", {31'd0, s_valid}, 1);
         chk("s_pc", {28'd0, s_pc}, k % 16);
         chk("s_instr", {23'd0, s_instr}, {23'd0, smem[k % 16]});
         chk("s_opcode", {29'd0, s_opcode}, {29'd0, smem[k % 16][8:6]});
         chk("s_cnt", {28'd0, s_cnt}, (k + 1 > 15) ? 15 : k + 1);
         tick(0, 0, 0, 0, 0);
      end
      s_bt = 1; s_tg = 4'd15; tick(0, 0, 0, 0, 0);
      s_bt = 0;
      chk("s_bubble", {31'd0, s_valid}, 0);
      tick(0, 0, 0, 0, 0);
      chk("s_tgt_pc", {28'd0, s_pc}, 15);
      chk("s_tgt_valid", {31'd0, s_valid}, 1);
      tick(0, 0, 0, 0, 0);
      chk("s_wrap_pc", {28'd0, s_pc}, 0);
      s_halt = 1; tick(0, 0, 0, 0, 0);
      s_halt = 0;
      chk("s_done", {31'd0, s_done}, 1);
      chk("s_running", {31'd0, s_running}, 0);
      chk("s_bbits", {30'd0, s_bbits}, 0);

      // Main: start, sequential run with ignored start pulses, branch at pc 5
      tick(0, 1, 0, 0, 0);
      tick(0, 0, 0, 0, 0);
      for (int i = 0; i < 20 && !(m_valid() && m_pc == 5); i++)
         tick(0, 1'($urandom_range(0, 1)), 0, 0, 0);
      chk("reach_pc5", {22'd0, pc}, 5);
      chk("count_at_pc5", {16'd0, cycle_count}, 6);
      tick(0, 0, 0, 1, 'h20);
      chk("branch_bubble_op", {29'd0, opcode}, 0);
      tick(0, 0, 0, 0, 0);
      chk("branch_tgt", {22'd0, pc}, 'h20);
      tick(0, 0, 0, 0, 0);
      chk("branch_tgt1", {22'd0, pc}, 'h21);

      // Random branches; halt and branch requests on squashed slots must be ignored
      for (int i = 0; i < 60; i++) begin
         if (m_bub) tick(0, 1'($urandom_range(0, 1)), 1, 1, $urandom_range(0, 1023));
         else tick(0, 1'($urandom_range(0, 3) == 0), 0, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 1023));
      end

      // Halt with simultaneous branch at pc 7
      to_valid();
      tick(0, 0, 0, 1, 7);
      tick(0, 0, 1, 0, 0);
      chk("reach_pc7", {22'd0, pc}, 7);
      tick(0, 0, 1, 1, 'h55);
      chk("halt_done", {31'd0, done}, 1);
      chk("halt_valid", {31'd0, instr_valid}, 0);
      cc = m_cnt;
      repeat (10) tick(0, 0, 0, 0, 0);
      chk("count_frozen", {16'd0, cycle_count}, cc);
      chk("pc_frozen", {22'd0, pc}, 7);

      // Rerun from the entry address
      tick(0, 1, 0, 0, 0);
      chk("restart_cnt_clr", {16'd0, cycle_count}, 0);
      tick(0, 0, 0, 0, 0);
      chk("restart_pc", {22'd0, pc}, 0);

      // Self-branch at 3: valid, bubble, valid, ...
      for (int i = 0; i < 8 && !(m_valid() && m_pc == 3); i++) tick(0, 0, 0, 0, 0);
      chk("reach_pc3", {22'd0, pc}, 3);
      for (int i = 0; i < 6; i++) begin
         chk("selfloop_valid", {31'd0, instr_valid}, (i % 2 == 0) ? 1 : 0);
         tick(0, 0, 0, 1, 3);
      end

      // Address wrap at the top of the 10-bit space
      to_valid();
      tick(0, 0, 0, 1, 1022);
      tick(0, 0, 0, 0, 0);
      for (int k = 0; k < 4; k++) begin
         chk("wrap_pc", {22'd0, pc}, (1022 + k) % 1024);
         tick(0, 0, 0, 0, 0);
      end
      tick(0, 0, 0, 1, 1023);
      tick(0, 0, 0, 0, 0);
      chk("tgt_top", {22'd0, pc}, 1023);
      tick(0, 0, 0, 0, 0);
      chk("tgt_top_wrap", {22'd0, pc}, 0);

      // Reset mid-run at pc 9 while a squash is pending
      to_valid();
      tick(0, 0, 0, 1, 9);
      tick(0, 0, 0, 0, 0);
      chk("reach_pc9", {22'd0, pc}, 9);
      tick(0, 0, 0, 1, 'h100);
      tick(1, 0, 0, 0, 0);
      chk("rst_valid", {31'd0, instr_valid}, 0);
      chk("rst_pc", {22'd0, pc}, 0);
      chk("rst_cnt", {16'd0, cycle_count}, 0);
      tick(1, 1, 0, 0, 0);
      tick(0, 0, 0, 0, 0);
      chk("rst_wins_start", {31'd0, running}, 0);
      tick(0, 1, 0, 0, 0);
      tick(0, 0, 0, 0, 0);
      chk("post_rst_valid", {31'd0, instr_valid}, 1);
      chk("post_rst_pc", {22'd0, pc}, 0);
      repeat (3) tick(0, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the controller.
- Owns the program counter, sequences a synchronous-read instruction memory, and slices each fetched instruction into the controller's opcode and branch_bits fields.
- Handles the program start/done handshake, taken-branch redirect with a one-slot squash, and a run-cycle counter.

Parameters:
- PC_W, 10, program counter / instruction address width.
- INSTR_W, 9, instruction width; opcode = instr[8:6], branch_bits = instr[5:4].
- RESET_PC, 0, program entry address.
- CNT_W, 16, cycle counter width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high; returns block to IDLE.
- start  in  1  one-cycle pulse; begins execution at RESET_PC.
- halt_req  in  1  controller done; qualified by instr_valid.
- branch_taken  in  1  branch resolved taken for the current instr; qualified by instr_valid.
- branch_target  in  PC_W  absolute target PC, valid with branch_taken.
- imem_addr  out  PC_W  instruction memory read address; data returns next cycle.
- imem_rdata  in  INSTR_W  instruction memory read data.
- instr  out  INSTR_W  current instruction, zero when not valid.
- instr_valid  out  1  instr / opcode / branch_bits / pc are meaningful this cycle.
- opcode  out  3  instr[8:6] to controller.
- branch_bits  out  2  instr[5:4] to controller.
- pc  out  PC_W  address of the current instr.
- running  out  1  high in PRIME and RUN.
- done  out  1  high in HALTED.
- cycle_count  out  CNT_W  cycles spent in PRIME and RUN.

Behaviour:
Reset values:
- State IDLE.
- instr = 0, instr_valid = 0, opcode = 0, branch_bits = 0.
- pc = RESET_PC, imem_addr = RESET_PC, fetch_pc = RESET_PC.
- running = 0, done = 0, cycle_count = 0.

States:
- IDLE
  - imem_addr = RESET_PC, instr_valid = 0.
  - start -> PRIME; fetch_pc <= RESET_PC; cycle_count <= 0.
- PRIME (exactly 1 cycle)
  - imem_addr = fetch_pc; fetch_pc <= fetch_pc + 1.
  - -> RUN.
- RUN
  - instr = imem_rdata of the previous cycle's address; pc = that address.
  - instr_valid = 1 unless the slot is squashed.
  - Normal cycle: imem_addr = fetch_pc; fetch_pc <= fetch_pc + 1. One instruction per cycle, latency 1 from address to instr.
  - Taken branch (branch_taken & instr_valid at cycle t):
    - The slot arriving at t+1 (the sequential successor) is squashed: instr_valid = 0, instr = 0, opcode = 0, branch_bits = 0.
    - At t+1, imem_addr = branch_target and fetch_pc <= branch_target + 1.
    - The target instruction is valid at t+2 with pc = branch_target. Penalty is 1 bubble.
  - branch_taken while instr_valid = 0 (squashed slot) is ignored.
  - halt_req & instr_valid -> HALTED. The halting instruction is the last valid one. halt_req has priority over branch_taken in the same cycle.
- HALTED
  - instr_valid = 0, done = 1 held, cycle_count and pc frozen.
  - start -> PRIME (rerun from RESET_PC, counter cleared, done drops next cycle).

Width and wrap rules:
- fetch_pc and branch_target wrap modulo 2^PC_W. Address 2^PC_W-1 is followed by 0; this is not an error.
- cycle_count increments in PRIME and RUN and saturates at 2^CNT_W-1.

Boundary and priority rules:
- start in PRIME or RUN is ignored.
- start in the same cycle as reset: reset wins.
- reset mid-RUN: next cycle matches the reset values above, and no squash state survives.
- A branch to its own address (tight loop) repeats every 2 cycles: valid, bubble, valid.
- halt_req with instr_valid = 0 is ignored.

Test Plan:
- Reset, then start pulse; imem holds instr k at address k.
  - PRIME at cycle 1.
  - instr_valid first at cycle 2 with pc = 0, and pc increments 0, 1, 2, 3 each cycle.
  - opcode = imem[k][8:6], branch_bits = imem[k][5:4].
  - cycle_count = 4 after 4 RUN cycles.
- branch_taken = 1, branch_target = 0x20 while pc = 5.
  - Next cycle instr_valid = 0 and opcode = 0.
  - Following cycle pc = 0x20 with valid instr, then pc = 0x21.
- halt_req and branch_taken both high at pc = 7.
  - Next cycle done = 1, instr_valid = 0, running = 0.
  - cycle_count stays frozen for 10 further cycles.
  - A start pulse restarts at pc = 0 with cycle_count cleared.
- PC_W = 4, no branches.
  - pc sequence 14, 15, 0, 1 with no invalid slot.
  - branch_target = 15 gives pc = 15 then 0.
- reset asserted mid-RUN at pc = 9 with a pending squash.
  - Next cycle: instr_valid = 0, pc = RESET_PC, running = 0, done = 0, cycle_count = 0.
- Other cases:
  - start during RUN has no effect.
  - halt_req during a squashed slot is ignored and execution continues.
  - A self-branch at address 3 alternates valid pc = 3 with a bubble.
